// File: rtl/mac_shiftadd_core_if.sv
// Operand/control/result bundle between the TT pin wrapper (master) and the
// shift-add MAC core (slave).
interface mac_shiftadd_core_if #(
  parameter int W     = 8,
  parameter int ACC_W = 2 * W + 4
);
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic             start;
  logic             signed_mode;
  logic             acc_mode;
  logic             clear_acc;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic             overflow;

  modport master (
    output a_in, b_in, start, signed_mode, acc_mode, clear_acc,
    input  busy, done, result, overflow
  );

  modport slave (
    input  a_in, b_in, start, signed_mode, acc_mode, clear_acc,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/mac_shiftadd_core.sv
// Sequential shift-add multiplier with per-op signedness, fixed-point rescale
// (round half up) and a saturating/wrapping signed accumulator.
module mac_shiftadd_core #(
  parameter int W         = 8,
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 2 * W + 4,
  parameter int SAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  mac_shiftadd_core_if.slave   bus
);

  localparam int PW  = 2 * W + 2;
  localparam int CW  = $clog2(W + 1);
  localparam int HSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  // Rounding offset 2^(FRAC_BITS-1), or zero when no rescale is requested.
  localparam logic signed [PW-1:0] HALF = PW'(FRAC_BITS > 0) << HSH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 clr_now;
  logic                 step;
  logic                 finish;

  logic [2*W-1:0]       mcand;
  logic [W-1:0]         mpr;
  logic [2*W-1:0]       prod;
  logic [CW-1:0]        cnt;
  logic                 sign;
  logic                 acc_mode_l;
  logic                 busy;
  logic                 done;
  logic [ACC_W-1:0]     result;
  logic                 overflow;

  logic signed [PW-1:0] mag_ext;
  logic signed [PW-1:0] p_wide;
  logic signed [PW-1:0] p_round;
  logic signed [ACC_W:0] p_ext;
  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] sum;
  logic                 sum_ovf;
  logic [ACC_W-1:0]     sat_val;

  function automatic logic [W-1:0] mag_of(input logic [W-1:0] x, input logic is_signed);
    // The most negative value maps onto itself, which is the correct unsigned magnitude.
    return (is_signed && x[W-1]) ? (~x + W'(1)) : x;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and per-edge action strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clr_now   = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (ena) begin
      case (state)
        S_IDLE, S_DONE: begin
          clr_now = bus.clear_acc;
          if (bus.start) begin
            accept    = 1'b1;
            state_nxt = S_RUN;
          end else begin
            state_nxt = state;
          end
        end
        S_RUN: begin
          step = 1'b1;
          if (cnt == CW'(W - 1)) begin
            state_nxt = S_POST;
          end else begin
            state_nxt = S_RUN;
          end
        end
        S_POST: begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Sign application, rescale and accumulate/saturate of the finished product
  always_comb begin
    mag_ext = {2'b00, prod};
    p_wide  = sign ? -mag_ext : mag_ext;
    p_round = (p_wide + HALF) >>> FRAC_BITS;
    p_ext   = (ACC_W + 1)'(p_round);
    acc_ext = {result[ACC_W-1], result};
    sum     = acc_mode_l ? (acc_ext + p_ext) : p_ext;
    sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  // Datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      mpr        <= '0;
      prod       <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      acc_mode_l <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else if (ena) begin
      // Clear is applied before a same-edge start, so an accumulate op then sees zero.
      if (clr_now) begin
        result   <= '0;
        overflow <= 1'b0;
        done     <= 1'b0;
      end
      if (accept) begin
        mcand      <= {{W{1'b0}}, mag_of(bus.a_in, bus.signed_mode)};
        mpr        <= mag_of(bus.b_in, bus.signed_mode);
        sign       <= bus.signed_mode & (bus.a_in[W-1] ^ bus.b_in[W-1]);
        acc_mode_l <= bus.acc_mode;
        prod       <= '0;
        cnt        <= '0;
        busy       <= 1'b1;
        done       <= 1'b0;
      end
      if (step) begin
        if (mpr[0]) begin
          prod <= prod + mcand;
        end
        mpr   <= {1'b0, mpr[W-1:1]};
        mcand <= {mcand[2*W-2:0], 1'b0};
        cnt   <= cnt + CW'(1);
      end
      if (finish) begin
        if (sum_ovf) begin
          overflow <= 1'b1;
          result   <= (SAT != 0) ? sat_val : sum[ACC_W-1:0];
        end else begin
          result   <= sum[ACC_W-1:0];
        end
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = result;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_mac_shiftadd_core.sv
// Drives three core builds (default, wrap-on-overflow, FRAC_BITS=4) with the
// same stimulus and checks each against a behavioural arithmetic model.
module tb_mac_shiftadd_core;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;
  logic       start = 1'b0;
  logic       sm    = 1'b0;
  logic       am    = 1'b0;
  logic       clr   = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_shiftadd_core_if #(.W(8), .ACC_W(20)) bus0 ();
  mac_shiftadd_core_if #(.W(8), .ACC_W(20)) bus1 ();
  mac_shiftadd_core_if #(.W(8), .ACC_W(20)) bus2 ();

  assign bus0.a_in = a;  assign bus0.b_in = b;  assign bus0.start = start;
  assign bus0.signed_mode = sm;  assign bus0.acc_mode = am;  assign bus0.clear_acc = clr;
  assign bus1.a_in = a;  assign bus1.b_in = b;  assign bus1.start = start;
  assign bus1.signed_mode = sm;  assign bus1.acc_mode = am;  assign bus1.clear_acc = clr;
  assign bus2.a_in = a;  assign bus2.b_in = b;  assign bus2.start = start;
  assign bus2.signed_mode = sm;  assign bus2.acc_mode = am;  assign bus2.clear_acc = clr;

  mac_shiftadd_core #(.W(8), .FRAC_BITS(0), .ACC_W(20), .SAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0));
  mac_shiftadd_core #(.W(8), .FRAC_BITS(0), .ACC_W(20), .SAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1));
  mac_shiftadd_core #(.W(8), .FRAC_BITS(4), .ACC_W(20), .SAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus2));

  // Reference model state per build
  localparam longint MAXV = 64'sd524287;
  localparam longint MINV = -64'sd524288;
  longint m_acc [3];
  bit     m_ovf [3];
  int     cfg_frac [3] = '{0, 0, 4};
  bit     cfg_sat  [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic [2:0][19:0] r;
    logic [2:0]       o;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    bit          acm;
    bit          c;
    logic [19:0] r;
    bit          o;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint res_of(input int k);
    if (k == 0) return longint'(bus0.result);
    else if (k == 1) return longint'(bus1.result);
    else return longint'(bus2.result);
  endfunction

  function automatic longint ovf_of(input int k);
    if (k == 0) return longint'(bus0.overflow);
    else if (k == 1) return longint'(bus1.overflow);
    else return longint'(bus2.overflow);
  endfunction

  task automatic model_op(input int k, input logic [7:0] x, input logic [7:0] y,
                          input bit s, input bit acm, input bit c);
    longint sx, sy, p, sum, w;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    if (cfg_frac[k] > 0) p = (p + (longint'(1) << (cfg_frac[k] - 1))) >>> cfg_frac[k];
    if (c) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
    sum = acm ? m_acc[k] + p : p;
    if (sum > MAXV || sum < MINV) begin
      m_ovf[k] = 1'b1;
      if (cfg_sat[k]) begin
        m_acc[k] = (sum > MAXV) ? MAXV : MINV;
      end else begin
        w = sum & 64'h00000000000FFFFF;
        if (w >= 64'sd524288) w = w - 64'sd1048576;
        m_acc[k] = w;
      end
    end else begin
      m_acc[k] = sum;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Launch one op, optionally stall ena or inject a stray start, then score it.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit s,
                        input bit acm, input bit c, input int pause_at,
                        input int mid_at, input int exp_lat);
    exp_t e;
    int   n;
    bit   busy_ok;
    @(negedge clk);
    a = x; b = y; sm = s; am = acm; clr = c; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      model_op(k, x, y, s, acm, c);
      e.r[k] = m_acc[k][19:0];
      e.o[k] = m_ovf[k];
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0; a = 8'hA5; b = 8'h5A;
    chk("busy_at_start", longint'(bus0.busy), 1);
    chk("done_at_start", longint'(bus0.done), 0);
    n = 0;
    busy_ok = 1'b1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == pause_at) ena = 1'b0;
      if (n == pause_at + 3) ena = 1'b1;
      if (n == mid_at) begin
        start = 1'b1; a = 8'h12; b = 8'h34; am = 1'b1;
      end else if (n == mid_at + 1) begin
        start = 1'b0;
      end
      if (bus0.done) break;
      if (!bus0.busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    ena   = 1'b1;
    chk("latency", n, exp_lat);
    chk("busy_held", longint'(busy_ok), 1);
    chk("busy_cleared", longint'(bus0.busy), 0);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("result_dut%0d", k), res_of(k), longint'(e.r[k]));
        chk($sformatf("overflow_dut%0d", k), ovf_of(k), longint'(e.o[k]));
      end
    end
  endtask

  task automatic clear_only();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clear();
  endtask

  initial begin
    tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 20'h0FE01, 1'b0};
    tbl[1]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 20'hFC080, 1'b0};
    tbl[2]  = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 20'h04000, 1'b0};
    tbl[3]  = '{8'h00, 8'hAA, 1'b0, 1'b0, 1'b0, 20'h00000, 1'b0};
    tbl[4]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 20'h0FE01, 1'b0};
    tbl[5]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h1FC02, 1'b0};
    tbl[6]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h2FA03, 1'b0};
    tbl[7]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h3F804, 1'b0};
    tbl[8]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h4F605, 1'b0};
    tbl[9]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h5F406, 1'b0};
    tbl[10] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h6F207, 1'b0};
    tbl[11] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h7F008, 1'b0};
    tbl[12] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'h7FFFF, 1'b1};
    tbl[13] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1, 20'h03F01, 1'b0};
    tbl[14] = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 20'h03F00, 1'b0};
    tbl[15] = '{8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 20'h000FF, 1'b0};
    tbl[16] = '{8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 20'h00000, 1'b0};
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", longint'(bus0.busy), 0);
    chk("reset_done", longint'(bus0.done), 0);
    chk("reset_result", longint'(bus0.result), 0);
    chk("reset_overflow", longint'(bus0.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].acm, tbl[i].c, 0, 0, 9);
      chk($sformatf("vec%0d_result", i), longint'(bus0.result), longint'(tbl[i].r));
      chk($sformatf("vec%0d_overflow", i), longint'(bus0.overflow), longint'(tbl[i].o));
      if (i == 12) begin
        chk("wrap_result", longint'(bus1.result), 64'h8EE09);
        chk("wrap_overflow", longint'(bus1.overflow), 1);
        clear_only();
        chk("clear_result", longint'(bus0.result), 0);
        chk("clear_overflow", longint'(bus0.overflow), 0);
        chk("clear_done", longint'(bus0.done), 0);
        chk("clear_wrap_result", longint'(bus1.result), 0);
      end
    end

    // Fixed-point rescale: 1.5 rounds to 2, -1.5 rounds to -1
    run_op(8'h18, 8'h01, 1'b0, 1'b0, 1'b1, 0, 0, 9);
    chk("frac_pos_round", longint'(bus2.result), 64'h00002);
    run_op(8'hE8, 8'h01, 1'b1, 1'b0, 1'b0, 0, 0, 9);
    chk("frac_neg_round", longint'(bus2.result), 64'hFFFFF);
    chk("frac_neg_raw", longint'(bus0.result), 64'hFFFE8);

    // Stray start mid-RUN must not disturb the in-flight op
    run_op(8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0, 0, 3, 9);
    chk("mid_start_result", longint'(bus0.result), 64'h000E1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_start_no_relaunch", longint'(bus0.busy), 0);

    // ena low for three edges mid-RUN stretches latency by exactly three
    run_op(8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 4, 0, 12);
    chk("ena_pause_result", longint'(bus0.result), 64'h0000F);

    // Asynchronous reset mid-RUN aborts with no partial result
    @(negedge clk);
    a = 8'h55; b = 8'h55; sm = 1'b0; am = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", longint'(bus0.busy), 0);
    chk("rst_mid_done", longint'(bus0.done), 0);
    chk("rst_mid_result", longint'(bus0.result), 0);
    chk("rst_mid_frac_result", longint'(bus2.result), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h02, 8'h03, 1'b0, 1'b1, 1'b0, 0, 0, 9);
    chk("after_reset_result", longint'(bus0.result), 64'h00006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
